obi_ram_bridge: RTL and testbench

OBI_RAM_BRIDGE -- requirements
Module: obi_ram_bridge

---
 rtl/obi_ram_pkg.sv | 14 +
 rtl/obi_ram_bridge_if.sv | 34 +++
 rtl/obi_ram_lfsr.sv | 20 ++
 rtl/obi_ram_bridge.sv | 105 ++++++++++
 tb/tb_obi_ram_bridge.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/obi_ram_pkg.sv
// Shared types and constants for the OBI-to-RAM bridge and its stall generator.
package obi_ram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } stall_state_e;

    localparam int          STALL_W           = 3;
    // Fibonacci taps 16,14,13,11 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/obi_ram_bridge_if.sv
// OBI data port plus RAM port of the bridge; slave modport is the bridge side.
interface obi_ram_bridge_if #(
    parameter int ADDR_WIDTH = 22
);

    logic                  data_req_i;
    logic                  data_gnt_o;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic [3:0]            data_be_i;
    logic [31:0]           data_wdata_i;
    logic                  data_rvalid_o;
    logic [31:0]           data_rdata_o;

    logic                  ram_en_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [3:0]            ram_be_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, ram_rdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
               ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o
    );

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, ram_rdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
               ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o
    );

endinterface

// File: rtl/obi_ram_lfsr.sv
// 16-bit Fibonacci LFSR stepping every cycle; loads seed under synchronous reset.
module obi_ram_lfsr
    import obi_ram_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // NOTE: non-blocking assignment so every flop samples the pre-edge state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= seed;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/obi_ram_bridge.sv
// OBI data port to 1-cycle-latency RAM bridge; define OBI_RAM_STALL_EN to insert
// pseudo-random grant stalls for protocol stress.
module obi_ram_bridge
    import obi_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH = 22,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    obi_ram_bridge_if.slave bus
);

    logic                  gnt;
    logic                  handshake;
    logic                  rvalid_q;
    logic                  was_read_q;
    logic [ADDR_WIDTH-1:0] addr;

    assign addr      = bus.data_addr_i;
    assign handshake = bus.data_req_i & gnt;

    // Request fields go straight to the RAM; only the enable is qualified.
    assign bus.ram_en_o    = handshake;
    assign bus.ram_we_o    = bus.data_we_i;
    assign bus.ram_addr_o  = addr;
    assign bus.ram_be_o    = bus.data_be_i;
    assign bus.ram_wdata_o = bus.data_wdata_i;
    assign bus.data_gnt_o  = gnt;

`ifdef OBI_RAM_STALL_EN
    stall_state_e       state;
    logic [STALL_W-1:0] cnt;
    logic [15:0]        lfsr_state;
    logic [STALL_W-1:0] n;
    logic               unused_lfsr_bits;

    obi_ram_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .seed   (LFSR_SEED),
        .state  (lfsr_state)
    );

    assign n                = lfsr_state[STALL_W-1:0];
    assign unused_lfsr_bits = ^lfsr_state[15:STALL_W];

    // NOTE: default first so no path through the case leaves gnt unassigned (no latch).
    always_comb begin
        gnt = 1'b0;
        if (rst_ni) begin
            case (state)
                IDLE:    gnt = bus.data_req_i && (n == '0);
                WAIT:    gnt = bus.data_req_i && (cnt == '0);
                default: gnt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_req_i && (n != '0)) begin
                        cnt   <= n - 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A dropped request is a protocol violation; abandon the stall.
                    if (!bus.data_req_i || (cnt == '0)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_seed;

    assign unused_seed = ^LFSR_SEED;
    assign gnt         = bus.data_req_i & rst_ni;
`endif

    // OBI responses have no backpressure, so a single response register suffices.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q   <= 1'b0;
            was_read_q <= 1'b0;
        end else begin
            rvalid_q   <= handshake;
            was_read_q <= handshake & ~bus.data_we_i;
        end
    end

    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rdata_o  = (rvalid_q && was_read_q) ? bus.ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_obi_ram_bridge.sv
// Directed bench for obi_ram_bridge with a byte-lane RAM model and a response scoreboard.
module tb_obi_ram_bridge;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    logic prev_hs = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   resp_cnt = 0;
    int   waited;
    int   start_cnt;

    logic [31:0] sb[$];
    bit   [31:0] ram   [0:255];
    bit   [31:0] model [0:255];

    always #5 clk = ~clk;

    obi_ram_bridge_if #(.ADDR_WIDTH(22)) bus ();

    obi_ram_bridge #(
        .ADDR_WIDTH (22),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // RAM with registered read data and byte-enable writes.
    always @(posedge clk) begin
        if (bus.ram_en_o === 1'b1) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_be_o[b]) ram[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
                end
            end else begin
                bus.ram_rdata_i <= ram[bus.ram_addr_o[9:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: rvalid exactly one cycle after each handshake, data from the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] exp_word;
            logic [7:0]  idx;
            check("rvalid_timing", {31'b0, bus.data_rvalid_o}, {31'b0, prev_hs});
            if (bus.data_rvalid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL sb_underflow: observed=rvalid expected=no_response");
                end else begin
                    exp_word = sb.pop_front();
                    check("rdata", bus.data_rdata_o, exp_word);
                    resp_cnt++;
                end
            end else begin
                check("rdata_idle", bus.data_rdata_o, 32'h0);
            end
            prev_hs = bus.data_req_i & bus.data_gnt_o;
            if (prev_hs) begin
                idx = bus.data_addr_i[9:2];
                if (bus.data_we_i) begin
                    sb.push_back(32'h0);
                    for (int b = 0; b < 4; b++) begin
                        if (bus.data_be_i[b]) model[idx][8*b +: 8] = bus.data_wdata_i[8*b +: 8];
                    end
                end else begin
                    sb.push_back(model[idx]);
                end
            end
        end
    end

    task automatic access(input logic we, input logic [21:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output int wcnt);
        @(posedge clk);
        #1;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = we;
        bus.data_addr_i  = addr;
        bus.data_be_i    = be;
        bus.data_wdata_i = wdata;
        wcnt = 0;
        @(negedge clk);
        while (bus.data_gnt_o !== 1'b1 && wcnt < 20) begin
            wcnt++;
            @(negedge clk);
        end
        check("gnt", {31'b0, bus.data_gnt_o}, 32'h1);
        check("ram_en", {31'b0, bus.ram_en_o}, 32'h1);
        check("ram_we", {31'b0, bus.ram_we_o}, {31'b0, we});
        check("ram_addr", {10'b0, bus.ram_addr_o}, {10'b0, addr});
        check("ram_be", {28'b0, bus.ram_be_o}, {28'b0, be});
        check("ram_wdata", bus.ram_wdata_o, wdata);
`ifndef OBI_RAM_STALL_EN
        check("zero_wait", wcnt, 0);
`endif
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1;
        bus.data_req_i = 1'b0;
    endtask

    task automatic single(input logic we, input logic [21:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp, input string tag);
        int w;
        access(we, addr, be, wdata, w);
        drop_req();
        @(negedge clk);
        check({tag, "_rvalid"}, {31'b0, bus.data_rvalid_o}, 32'h1);
        check({tag, "_rdata"}, bus.data_rdata_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_be_i    = 4'h0;
        bus.data_wdata_i = 32'h0;

        // Reset with a request pending: no grant, no RAM enable, no response.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        bus.data_req_i = 1'b1;
        @(negedge clk);
        check("rst_gnt", {31'b0, bus.data_gnt_o}, 32'h0);
        check("rst_ram_en", {31'b0, bus.ram_en_o}, 32'h0);
        check("rst_rvalid", {31'b0, bus.data_rvalid_o}, 32'h0);
        check("rst_rdata", bus.data_rdata_o, 32'h0);
        @(posedge clk);
        #1;
        bus.data_req_i = 1'b0;
        rst_n = 1'b1;

        single(1'b1, 22'h100, 4'hF, 32'hDEADBEEF, 32'h0, "wr_full");
        single(1'b0, 22'h100, 4'hF, 32'h0, 32'hDEADBEEF, "rd_full");

        single(1'b1, 22'h000, 4'hF, 32'h11111111, 32'h0, "wr_0");
        single(1'b1, 22'h004, 4'hF, 32'h22222222, 32'h0, "wr_4");
        single(1'b1, 22'h008, 4'hF, 32'h33333333, 32'h0, "wr_8");

        // Back-to-back reads; the monitor checks order and one-cycle spacing.
        start_cnt = resp_cnt;
        access(1'b0, 22'h000, 4'hF, 32'h0, waited);
        access(1'b0, 22'h004, 4'hF, 32'h0, waited);
        access(1'b0, 22'h008, 4'hF, 32'h0, waited);
        check("b2b_last_rdata", bus.data_rdata_o, 32'h22222222);
        drop_req();
        @(negedge clk);
        check("b2b_final_rdata", bus.data_rdata_o, 32'h33333333);
        check("b2b_resp_count", resp_cnt - start_cnt, 3);

        single(1'b1, 22'h102, 4'b0010, 32'h0000AB00, 32'h0, "wr_sub");
        single(1'b0, 22'h100, 4'hF, 32'h0, 32'hDEADABEF, "rd_sub");

`ifdef OBI_RAM_STALL_EN
        force dut.lfsr_state = 16'h0005;
        access(1'b0, 22'h004, 4'hF, 32'h0, waited);
        check("stall_cycles", waited, 5);
        drop_req();
        @(negedge clk);
        check("stall_idle", {31'b0, dut.state}, 32'h0);
        release dut.lfsr_state;
`endif

        // Reset in the cycle after a read grant drops any later response.
        access(1'b0, 22'h008, 4'hF, 32'h0, waited);
        @(posedge clk);
        #1;
        bus.data_req_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_rvalid", {31'b0, bus.data_rvalid_o}, 32'h0);
`ifdef OBI_RAM_STALL_EN
        check("mid_rst_lfsr", {16'b0, dut.lfsr_state}, 32'h0000ACE1);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rvalid", {31'b0, bus.data_rvalid_o}, 32'h0);
        end

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
